// File: rtl/alu_pkg.sv
// Shared definitions for the execute-stage ALU / multiply-divide unit:
// function codes, sequencer states and small decode helpers.
package alu_pkg;

    typedef enum logic [5:0] {
        F_SLL   = 6'b000000,
        F_SRL   = 6'b000010,
        F_SRA   = 6'b000011,
        F_SLLV  = 6'b000100,
        F_SRLV  = 6'b000110,
        F_MFHI  = 6'b010000,
        F_MFLO  = 6'b010010,
        F_MULT  = 6'b011000,
        F_MULTU = 6'b011001,
        F_DIV   = 6'b011010,
        F_DIVU  = 6'b011011,
        F_ADDU  = 6'b100001,
        F_SUB   = 6'b100010,
        F_SUBU  = 6'b100011,
        F_AND   = 6'b100100,
        F_OR    = 6'b100101,
        F_XOR   = 6'b100110,
        F_NOR   = 6'b100111,
        F_SLT   = 6'b101010,
        F_BEQ   = 6'b111000,
        F_BNE   = 6'b111001,
        F_BLEZ  = 6'b111010,
        F_BGTZ  = 6'b111011,
        F_BGEZ  = 6'b111100,
        F_LUI   = 6'b111101
    } func_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2,
        FIX  = 2'd3
    } mdu_state_e;

    function automatic logic func_is_mul(input logic [5:0] f);
        return (f == F_MULT) || (f == F_MULTU);
    endfunction

    function automatic logic func_is_div(input logic [5:0] f);
        return (f == F_DIV) || (f == F_DIVU);
    endfunction

    // Signed variants sign-correct their magnitude result afterwards.
    function automatic logic func_is_signed_mdu(input logic [5:0] f);
        return (f == F_MULT) || (f == F_DIV);
    endfunction

endpackage

// File: rtl/mdu_iter.sv
// Iterative multiply/divide datapath. Works on operand magnitudes: one
// shift-add (multiply) or restoring-subtract (divide) step per enabled
// cycle, then sign-corrects the final HI/LO combinationally from the last
// step so the sequencer can register the finished values on that edge.
module mdu_iter
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    localparam int SHW = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_start,
    input  logic             i_step,
    input  logic             i_is_div,
    input  logic             i_signed,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic             o_last,
    output logic [WIDTH-1:0] o_hi,
    output logic [WIDTH-1:0] o_lo,
    output logic             o_div0
);

    logic [SHW-1:0]     r_cnt;
    logic               r_is_div;
    logic               r_neg_q;
    logic               r_neg_r;
    logic               r_div0;
    logic [WIDTH-1:0]   r_acc_hi;
    logic [WIDTH-1:0]   r_acc_lo;
    logic [WIDTH-1:0]   r_md;

    logic [WIDTH:0]     w_sum;
    logic [WIDTH:0]     w_rem_sh;
    logic [WIDTH-1:0]   w_diff;
    logic               w_ge;
    logic [WIDTH-1:0]   w_hi_n;
    logic [WIDTH-1:0]   w_lo_n;
    logic [2*WIDTH-1:0] w_prod;
    logic [2*WIDTH-1:0] w_prod_fix;

    // Two's-complement magnitude; the most-negative value maps to 2^(WIDTH-1) as unsigned.
    function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] x, input logic neg);
        return neg ? -x : x;
    endfunction

    // Step counter and sign/zero-divisor bookkeeping captured at start.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt    <= '0;
            r_is_div <= 1'b0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_div0   <= 1'b0;
        end else if (i_start) begin
            r_cnt    <= '0;
            r_is_div <= i_is_div;
            r_neg_q  <= i_signed & (i_a[WIDTH-1] ^ i_b[WIDTH-1]);
            r_neg_r  <= i_signed & i_a[WIDTH-1];
            r_div0   <= i_is_div & (i_b == '0);
        end else if (i_step) begin
            r_cnt    <= r_cnt + 1'b1;
        end
    end

    // Accumulator: HI part / LO part (multiplier or dividend, then product or quotient).
    always_ff @(posedge clk) begin
        if (i_start) begin
            r_acc_hi <= '0;
            r_acc_lo <= mag(i_a, i_signed & i_a[WIDTH-1]);
            r_md     <= mag(i_b, i_signed & i_b[WIDTH-1]);
        end else if (i_step) begin
            r_acc_hi <= w_hi_n;
            r_acc_lo <= w_lo_n;
        end
    end

    // One iteration: shift-add for multiply, restoring subtract for divide.
    always_comb begin
        w_sum    = {1'b0, r_acc_hi} + (r_acc_lo[0] ? {1'b0, r_md} : '0);
        w_rem_sh = {r_acc_hi, r_acc_lo[WIDTH-1]};
        w_ge     = (w_rem_sh >= {1'b0, r_md});
        w_diff   = w_rem_sh[WIDTH-1:0] - r_md;
        if (r_is_div) begin
            w_hi_n = w_ge ? w_diff : w_rem_sh[WIDTH-1:0];
            w_lo_n = {r_acc_lo[WIDTH-2:0], w_ge};
        end else begin
            w_hi_n = w_sum[WIDTH:1];
            w_lo_n = {w_sum[0], r_acc_lo[WIDTH-1:1]};
        end
    end

    // Sign correction of the post-step value; a zero divisor forces LO to all ones,
    // while HI naturally ends up as the dividend once its sign is restored.
    always_comb begin
        w_prod     = {w_hi_n, w_lo_n};
        w_prod_fix = r_neg_q ? -w_prod : w_prod;
        if (r_is_div) begin
            o_lo = r_div0 ? '1 : mag(w_lo_n, r_neg_q);
            o_hi = mag(w_hi_n, r_neg_r);
        end else begin
            o_lo = w_prod_fix[WIDTH-1:0];
            o_hi = w_prod_fix[2*WIDTH-1:WIDTH];
        end
    end

    assign o_last = (r_cnt == SHW'(WIDTH - 1));
    assign o_div0 = r_div0;

endmodule

// File: rtl/alu_mdu.sv
// Execute-stage unit: single-cycle ALU plus an iterative multiply/divide
// sequencer with architectural HI/LO, behind a valid/ready handshake.
// Results, zero, div0 and illegal are registered and held until the next
// completion; out_valid pulses for one cycle per completed operation.
module alu_mdu
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    localparam int SHW = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [5:0]       func,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [SHW-1:0]   shamt,
    output logic             out_valid,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             div0,
    output logic             illegal
);

    mdu_state_e              r_state;
    logic [WIDTH-1:0]        r_hi;
    logic [WIDTH-1:0]        r_lo;
    logic [WIDTH-1:0]        r_result;
    logic                    r_zero;
    logic                    r_out_valid;
    logic                    r_div0;
    logic                    r_illegal;

    logic                    w_accept;
    logic                    w_is_mul;
    logic                    w_is_div;
    logic                    w_mdu_start;
    logic                    w_mdu_step;
    logic                    w_last;
    logic [WIDTH-1:0]        w_mdu_hi;
    logic [WIDTH-1:0]        w_mdu_lo;
    logic                    w_mdu_div0;
    logic [WIDTH-1:0]        w_alu_res;
    logic                    w_legal;
    logic signed [WIDTH-1:0] w_a_s;
    logic signed [WIDTH-1:0] w_b_s;

    assign in_ready    = (r_state == IDLE);
    assign w_accept    = in_valid & in_ready;
    assign w_is_mul    = func_is_mul(func);
    assign w_is_div    = func_is_div(func);
    assign w_mdu_start = w_accept & (w_is_mul | w_is_div);
    assign w_mdu_step  = (r_state == MUL) || (r_state == DIV);
    assign w_a_s       = a;
    assign w_b_s       = b;

    mdu_iter #(.WIDTH(WIDTH)) u_mdu (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_start  (w_mdu_start),
        .i_step   (w_mdu_step),
        .i_is_div (w_is_div),
        .i_signed (func_is_signed_mdu(func)),
        .i_a      (a),
        .i_b      (b),
        .o_last   (w_last),
        .o_hi     (w_mdu_hi),
        .o_lo     (w_mdu_lo),
        .o_div0   (w_mdu_div0)
    );

    // Single-cycle ALU result and function-code legality.
    always_comb begin
        w_alu_res = '0;
        w_legal   = 1'b1;
        case (func)
            F_XOR:   w_alu_res = a ^ b;
            F_SLL:   w_alu_res = b << shamt;
            F_SLLV:  w_alu_res = b << a[SHW-1:0];
            F_SRL:   w_alu_res = b >> shamt;
            F_SRA:   w_alu_res = w_b_s >>> shamt;
            F_SRLV:  w_alu_res = b >> a[SHW-1:0];
            F_SUB,
            F_SUBU:  w_alu_res = a - b;
            F_ADDU:  w_alu_res = a + b;
            F_AND:   w_alu_res = a & b;
            F_OR:    w_alu_res = a | b;
            F_NOR:   w_alu_res = ~(a | b);
            F_SLT:   w_alu_res[0] = (w_a_s < w_b_s);
            F_BEQ:   w_alu_res[0] = (a == b);
            F_BNE:   w_alu_res[0] = (a != b);
            F_BLEZ:  w_alu_res[0] = a[WIDTH-1] | (a == '0);
            F_BGTZ:  w_alu_res[0] = ~a[WIDTH-1] & (a != '0);
            F_BGEZ:  w_alu_res[0] = ~a[WIDTH-1];
            F_LUI:   w_alu_res = {b[WIDTH/2-1:0], {(WIDTH/2){1'b0}}};
            F_MFHI:  w_alu_res = r_hi;
            F_MFLO:  w_alu_res = r_lo;
            F_MULT,
            F_MULTU,
            F_DIV,
            F_DIVU:  w_alu_res = '0;
            default: w_legal = 1'b0;
        endcase
    end

    // Sequencer, HI/LO and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_hi        <= '0;
            r_lo        <= '0;
            r_result    <= '0;
            r_zero      <= 1'b1;
            r_out_valid <= 1'b0;
            r_div0      <= 1'b0;
            r_illegal   <= 1'b0;
        end else begin
            r_out_valid <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        if (w_is_mul) begin
                            r_state <= MUL;
                        end else if (w_is_div) begin
                            r_state <= DIV;
                        end else begin
                            r_result    <= w_alu_res;
                            r_zero      <= (w_alu_res == '0);
                            r_out_valid <= 1'b1;
                            r_div0      <= 1'b0;
                            r_illegal   <= ~w_legal;
                        end
                    end
                end
                MUL, DIV: begin
                    if (w_last) begin
                        r_hi        <= w_mdu_hi;
                        r_lo        <= w_mdu_lo;
                        r_result    <= w_mdu_lo;
                        r_zero      <= (w_mdu_lo == '0);
                        r_out_valid <= 1'b1;
                        r_div0      <= w_mdu_div0;
                        r_illegal   <= 1'b0;
                        r_state     <= FIX;
                    end
                end
                FIX:     r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

    assign out_valid = r_out_valid;
    assign result    = r_result;
    assign zero      = r_zero;
    assign div0      = r_div0;
    assign illegal   = r_illegal;

endmodule

// File: tb/tb_alu_mdu.sv
// Bench for alu_mdu: directed scenarios plus randomized operations checked
// against an arithmetic reference model of the instruction set.
module tb_alu_mdu;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [5:0]  func = '0;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic [4:0]  shamt = '0;
    logic        out_valid;
    logic [31:0] result;
    logic        zero;
    logic        div0;
    logic        illegal;

    logic        in_valid16 = 1'b0;
    logic        in_ready16;
    logic [5:0]  func16 = '0;
    logic [15:0] a16 = '0;
    logic [15:0] b16 = '0;
    logic [3:0]  shamt16 = '0;
    logic        out_valid16;
    logic [15:0] result16;
    logic        zero16;
    logic        div0_16;
    logic        illegal16;

    int n_vec = 0;
    int n_err = 0;
    logic [31:0] m_hi = '0;
    logic [31:0] m_lo = '0;

    logic [5:0] codes [28] = '{
        6'b100110, 6'b000000, 6'b000100, 6'b000010, 6'b000011, 6'b000110, 6'b100010,
        6'b100011, 6'b100001, 6'b100100, 6'b100101, 6'b100111, 6'b101010, 6'b011000,
        6'b011001, 6'b011010, 6'b011011, 6'b010000, 6'b010010, 6'b111000, 6'b111001,
        6'b111010, 6'b111011, 6'b111100, 6'b111101, 6'b111111, 6'b000001, 6'b101011
    };

    always #5 clk = ~clk;

    alu_mdu #(.WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .func(func), .a(a), .b(b), .shamt(shamt), .out_valid(out_valid),
        .result(result), .zero(zero), .div0(div0), .illegal(illegal)
    );

    alu_mdu #(.WIDTH(16)) dut16 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid16), .in_ready(in_ready16),
        .func(func16), .a(a16), .b(b16), .shamt(shamt16), .out_valid(out_valid16),
        .result(result16), .zero(zero16), .div0(div0_16), .illegal(illegal16)
    );

    initial begin
        #500000;
        $display("FAIL global_timeout got no finish want finish");
        $fatal(1, "timeout");
    end

    // Reference model: instruction semantics in plain arithmetic, HI/LO in m_hi/m_lo.
    task automatic model_op(input logic [5:0] f, input logic [31:0] x, input logic [31:0] y,
                            input logic [4:0] sh, output logic [31:0] r, output logic d0,
                            output logic il);
        longint sx;
        longint sy;
        logic [63:0] p;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        r = '0; d0 = 1'b0; il = 1'b0;
        case (f)
            6'b100110: r = x ^ y;
            6'b000000: r = y << sh;
            6'b000100: r = y << x[4:0];
            6'b000010: r = y >> sh;
            6'b000011: r = 32'(sy >>> sh);
            6'b000110: r = y >> x[4:0];
            6'b100010, 6'b100011: r = x - y;
            6'b100001: r = x + y;
            6'b100100: r = x & y;
            6'b100101: r = x | y;
            6'b100111: r = ~(x | y);
            6'b101010: r = {31'b0, sx < sy};
            6'b011000: begin p = 64'(sx * sy); m_hi = p[63:32]; m_lo = p[31:0]; r = m_lo; end
            6'b011001: begin p = {32'b0, x} * {32'b0, y}; m_hi = p[63:32]; m_lo = p[31:0]; r = m_lo; end
            6'b011010: begin
                if (y == 0) begin m_lo = '1; m_hi = x; d0 = 1'b1; end
                else begin m_lo = 32'(sx / sy); m_hi = 32'(sx % sy); end
                r = m_lo;
            end
            6'b011011: begin
                if (y == 0) begin m_lo = '1; m_hi = x; d0 = 1'b1; end
                else begin m_lo = x / y; m_hi = x % y; end
                r = m_lo;
            end
            6'b010000: r = m_hi;
            6'b010010: r = m_lo;
            6'b111000: r = {31'b0, x == y};
            6'b111001: r = {31'b0, x != y};
            6'b111010: r = {31'b0, sx <= 0};
            6'b111011: r = {31'b0, sx > 0};
            6'b111100: r = {31'b0, sx >= 0};
            6'b111101: r = {y[15:0], 16'h0000};
            default:   il = 1'b1;
        endcase
    endtask

    // Issue one op on the 32-bit unit; lat = cycles from accept to out_valid, -1 if none.
    task automatic run_op(input logic [5:0] f, input logic [31:0] x, input logic [31:0] y,
                          input logic [4:0] sh, output int lat);
        int w;
        bit seen;
        lat = -1;
        w = 0;
        while (!in_ready && w < 100) begin
            @(posedge clk); #1;
            w++;
        end
        if (in_ready) begin
            func = f; a = x; b = y; shamt = sh; in_valid = 1'b1;
            @(posedge clk); #1;
            in_valid = 1'b0;
            seen = 1'b0;
            for (int i = 1; i <= 80; i++) begin
                if (!seen) begin
                    if (out_valid) begin
                        lat = i;
                        seen = 1'b1;
                    end else begin
                        @(posedge clk); #1;
                    end
                end
            end
        end
    endtask

    task automatic test_reset();
        int lat;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
        n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
        n_vec++; if (result !== 32'h0) begin n_err++; $display("FAIL reset_result got %h want 0", result); end
        n_vec++; if ({zero, div0, illegal} !== 3'b100) begin n_err++; $display("FAIL reset_flags got %b want 100", {zero, div0, illegal}); end
        n_vec++; if ({result16, zero16, in_ready16} !== {16'h0, 2'b11}) begin n_err++; $display("FAIL reset16 got %h/%b/%b want 0/1/1", result16, zero16, in_ready16); end
        run_op(6'b010000, 32'h0, 32'h0, 5'd0, lat);
        n_vec++; if (result !== 32'h0 || lat != 1) begin n_err++; $display("FAIL reset_hi got %h lat %0d want 0 lat 1", result, lat); end
        run_op(6'b010010, 32'h0, 32'h0, 5'd0, lat);
        n_vec++; if (result !== 32'h0 || zero !== 1'b1) begin n_err++; $display("FAIL reset_lo got %h z%b want 0 z1", result, zero); end
    endtask

    task automatic test_sub();
        int lat;
        run_op(6'b100010, 32'd5, 32'd7, 5'd0, lat);
        n_vec++; if (lat != 1) begin n_err++; $display("FAIL sub_latency got %0d want 1", lat); end
        n_vec++; if (result !== 32'hFFFFFFFE) begin n_err++; $display("FAIL sub_result got %h want fffffffe", result); end
        n_vec++; if (zero !== 1'b0) begin n_err++; $display("FAIL sub_zero got %b want 0", zero); end
        @(posedge clk); #1;
        n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL sub_pulse got %b want 0", out_valid); end
        n_vec++; if (result !== 32'hFFFFFFFE) begin n_err++; $display("FAIL sub_hold got %h want fffffffe", result); end
    endtask

    task automatic test_shifts();
        int lat;
        run_op(6'b000011, 32'h0, 32'h80000000, 5'd4, lat);
        n_vec++; if (result !== 32'hF8000000) begin n_err++; $display("FAIL sra got %h want f8000000", result); end
        run_op(6'b000110, 32'd36, 32'h000000F0, 5'd0, lat);
        n_vec++; if (result !== 32'h0000000F) begin n_err++; $display("FAIL srlv got %h want 0000000f", result); end
        run_op(6'b111101, 32'h0, 32'h1234ABCD, 5'd0, lat);
        n_vec++; if (result !== 32'hABCD0000) begin n_err++; $display("FAIL lui got %h want abcd0000", result); end
    endtask

    task automatic test_mult();
        int lat;
        bit busy_ok;
        bit seen;
        while (!in_ready) begin @(posedge clk); #1; end
        func = 6'b011000; a = 32'hFFFFFFFD; b = 32'd7; shamt = '0; in_valid = 1'b1;
        @(posedge clk); #1;
        func = 6'b100001; a = 32'd1; b = 32'd1;
        lat = -1; busy_ok = 1'b1; seen = 1'b0;
        for (int i = 1; i <= 80; i++) begin
            if (!seen) begin
                if (out_valid) begin
                    lat = i; seen = 1'b1;
                end else begin
                    if (in_ready) busy_ok = 1'b0;
                    @(posedge clk); #1;
                end
            end
        end
        in_valid = 1'b0;
        n_vec++; if (lat != 33) begin n_err++; $display("FAIL mult_latency got %0d want 33", lat); end
        n_vec++; if (result !== 32'hFFFFFFEB) begin n_err++; $display("FAIL mult_result got %h want ffffffeb", result); end
        n_vec++; if (busy_ok !== 1'b1 || in_ready !== 1'b0) begin n_err++; $display("FAIL mult_busy got ok%b rdy%b want ok1 rdy0", busy_ok, in_ready); end
        @(posedge clk); #1;
        n_vec++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin n_err++; $display("FAIL mult_after got v%b r%b want v0 r1", out_valid, in_ready); end
        run_op(6'b010000, 32'h0, 32'h0, 5'd0, lat);
        n_vec++; if (result !== 32'hFFFFFFFF) begin n_err++; $display("FAIL mult_hi got %h want ffffffff", result); end
        run_op(6'b010010, 32'h0, 32'h0, 5'd0, lat);
        n_vec++; if (result !== 32'hFFFFFFEB) begin n_err++; $display("FAIL mult_lo got %h want ffffffeb", result); end
    endtask

    task automatic test_div();
        int lat;
        run_op(6'b011010, 32'hFFFFFFF9, 32'd2, 5'd0, lat);
        n_vec++; if (result !== 32'hFFFFFFFD || lat != 33) begin n_err++; $display("FAIL div_lo got %h lat %0d want fffffffd lat 33", result, lat); end
        run_op(6'b010000, 32'h0, 32'h0, 5'd0, lat);
        n_vec++; if (result !== 32'hFFFFFFFF) begin n_err++; $display("FAIL div_hi got %h want ffffffff", result); end
        run_op(6'b011011, 32'd9, 32'd0, 5'd0, lat);
        n_vec++; if (result !== 32'hFFFFFFFF || div0 !== 1'b1) begin n_err++; $display("FAIL divu0_lo got %h d%b want ffffffff d1", result, div0); end
        run_op(6'b010000, 32'h0, 32'h0, 5'd0, lat);
        n_vec++; if (result !== 32'd9 || div0 !== 1'b0) begin n_err++; $display("FAIL divu0_hi got %h d%b want 9 d0", result, div0); end
        run_op(6'b011010, 32'h80000000, 32'hFFFFFFFF, 5'd0, lat);
        n_vec++; if (result !== 32'h80000000 || div0 !== 1'b0) begin n_err++; $display("FAIL divmin_lo got %h d%b want 80000000 d0", result, div0); end
        run_op(6'b010000, 32'h0, 32'h0, 5'd0, lat);
        n_vec++; if (result !== 32'h0 || zero !== 1'b1) begin n_err++; $display("FAIL divmin_hi got %h z%b want 0 z1", result, zero); end
    endtask

    task automatic test_branch_illegal();
        int lat;
        run_op(6'b111100, 32'h0, 32'h0, 5'd0, lat);
        n_vec++; if (result !== 32'd1 || zero !== 1'b0) begin n_err++; $display("FAIL bgez got %h z%b want 1 z0", result, zero); end
        run_op(6'b111010, 32'd1, 32'h0, 5'd0, lat);
        n_vec++; if (result !== 32'd0 || zero !== 1'b1) begin n_err++; $display("FAIL blez got %h z%b want 0 z1", result, zero); end
        run_op(6'b111111, 32'h5, 32'h6, 5'd0, lat);
        n_vec++; if (illegal !== 1'b1 || result !== 32'h0 || lat != 1) begin n_err++; $display("FAIL illegal got i%b %h lat %0d want i1 0 lat 1", illegal, result, lat); end
        run_op(6'b100110, 32'h5, 32'h6, 5'd0, lat);
        n_vec++; if (illegal !== 1'b0 || result !== 32'h3) begin n_err++; $display("FAIL illegal_clear got i%b %h want i0 3", illegal, result); end
    endtask

    task automatic test_reset_mid();
        int lat;
        bit spurious;
        while (!in_ready) begin @(posedge clk); #1; end
        func = 6'b011011; a = 32'd1000; b = 32'd7; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        n_vec++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin n_err++; $display("FAIL rstmid_async got r%b v%b want r1 v0", in_ready, out_valid); end
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        spurious = 1'b0;
        repeat (40) begin
            @(posedge clk); #1;
            if (out_valid) spurious = 1'b1;
        end
        n_vec++; if (spurious !== 1'b0 || in_ready !== 1'b1) begin n_err++; $display("FAIL rstmid_quiet got sp%b r%b want sp0 r1", spurious, in_ready); end
        run_op(6'b010000, 32'h0, 32'h0, 5'd0, lat);
        n_vec++; if (result !== 32'h0) begin n_err++; $display("FAIL rstmid_hi got %h want 0", result); end
        run_op(6'b010010, 32'h0, 32'h0, 5'd0, lat);
        n_vec++; if (result !== 32'h0) begin n_err++; $display("FAIL rstmid_lo got %h want 0", result); end
    endtask

    task automatic test_w16();
        int lat;
        bit seen;
        func16 = 6'b011001; a16 = 16'hFFFF; b16 = 16'hFFFF; in_valid16 = 1'b1;
        @(posedge clk); #1;
        in_valid16 = 1'b0;
        lat = -1; seen = 1'b0;
        for (int i = 1; i <= 40; i++) begin
            if (!seen) begin
                if (out_valid16) begin lat = i; seen = 1'b1; end
                else begin @(posedge clk); #1; end
            end
        end
        n_vec++; if (lat != 17 || result16 !== 16'h0001) begin n_err++; $display("FAIL w16_lo got %h lat %0d want 0001 lat 17", result16, lat); end
        n_vec++; if (div0_16 !== 1'b0 || illegal16 !== 1'b0) begin n_err++; $display("FAIL w16_flags got d%b i%b want d0 i0", div0_16, illegal16); end
        @(posedge clk); #1;
        func16 = 6'b010000; in_valid16 = 1'b1;
        @(posedge clk); #1;
        in_valid16 = 1'b0;
        n_vec++; if (result16 !== 16'hFFFE || out_valid16 !== 1'b1) begin n_err++; $display("FAIL w16_hi got %h v%b want fffe v1", result16, out_valid16); end
    endtask

    task automatic test_random();
        int lat;
        int want_lat;
        logic [5:0]  f;
        logic [31:0] x;
        logic [31:0] y;
        logic [4:0]  sh;
        logic [31:0] er;
        logic        ed0;
        logic        eil;
        m_hi = '0;
        m_lo = '0;
        for (int k = 0; k < 250; k++) begin
            f  = codes[$urandom_range(0, 27)];
            x  = $urandom;
            y  = $urandom;
            sh = 5'($urandom_range(0, 31));
            case ($urandom_range(0, 7))
                0: y = '0;
                1: begin x = 32'h80000000; y = 32'hFFFFFFFF; end
                2: begin x = 32'($urandom_range(0, 20)) - 32'd10; y = 32'($urandom_range(0, 6)) - 32'd3; end
                3: x = y;
                default: ;
            endcase
            want_lat = ((f >= 6'b011000) && (f <= 6'b011011)) ? 33 : 1;
            model_op(f, x, y, sh, er, ed0, eil);
            run_op(f, x, y, sh, lat);
            n_vec++; if (lat != want_lat) begin n_err++; $display("FAIL rnd_lat f=%b got %0d want %0d", f, lat, want_lat); end
            n_vec++; if (result !== er) begin n_err++; $display("FAIL rnd_result f=%b a=%h b=%h sh=%0d got %h want %h", f, x, y, sh, result, er); end
            n_vec++; if (zero !== (er == 32'h0)) begin n_err++; $display("FAIL rnd_zero f=%b got %b want %b", f, zero, er == 32'h0); end
            n_vec++; if ({div0, illegal} !== {ed0, eil}) begin n_err++; $display("FAIL rnd_flags f=%b got %b want %b", f, {div0, illegal}, {ed0, eil}); end
        end
    endtask

    initial begin
        test_reset();
        test_sub();
        test_shifts();
        test_mult();
        test_div();
        test_branch_illegal();
        test_reset_mid();
        test_w16();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/alu_mdu.md
# alu_mdu

Parametrised execution unit for the MIPS-style core: single-cycle ALU operations plus an iterative multiply/divide unit with architectural HI/LO registers, behind a valid/ready handshake. It sits in the execute stage; decode drives `func`, operands and `shamt`, and writeback consumes `result` on `out_valid`. It extends the existing function-code set with unsigned multiply/divide, HI/LO moves, signed-correct arithmetic shift, divide-by-zero and illegal-code reporting.

## Interface

- `WIDTH`, 32, datapath width; must be a power of two, at least 8.
- `SHW`, localparam $clog2(WIDTH), shift-amount width.

- `clk`  in  1  clock; everything is on the rising edge.
- `rst_n`  in  1  reset; one clock, reset asynchronous and active-low.
- `in_valid`  in  1  operation presented.
- `in_ready`  out  1  unit can accept; equals (state == IDLE).
- `func`  in  6  operation code.
- `a`, `b`  in  WIDTH  operands (rs, rt).
- `shamt`  in  SHW  immediate shift amount.
- `out_valid`  out  1  one-cycle pulse; `result` and flags valid.
- `result`  out  WIDTH  registered result.
- `zero`  out  1  (result == 0), registered with `result`.
- `div0`  out  1  last accepted op was DIV/DIVU with b == 0.
- `illegal`  out  1  last accepted `func` was not a defined code.

## Operation

- Codes: XOR 100110, SLL 000000, SLLV 000100, SRL 000010, SRA 000011, SRLV 000110, SUB 100010, SUBU 100011, ADDU 100001, AND 100100, OR 100101, NOR 100111, SLT 101010 (signed), MULT 011000, MULTU 011001, DIV 011010, DIVU 011011, MFHI 010000, MFLO 010010, BEQ 111000, BNE 111001, BLEZ 111010, BGTZ 111011, BGEZ 111100, LUI 111101.
- Shifts: SLL/SRL/SRA use `shamt`; SLLV/SRLV use a[SHW-1:0]; SRA is arithmetic on `b` (sign-filled).
- Branch codes: `result` = comparison outcome zero-extended; BLEZ/BGTZ/BGEZ compare `a` signed against 0.
- LUI: `result` = {b[WIDTH/2-1:0], WIDTH/2 zeros}.
- MULT/MULTU: {HI,LO} = 2·WIDTH-bit product; `result` = new LO.
- DIV/DIVU: LO = quotient (truncates toward zero), HI = remainder (sign of dividend); `result` = new LO.
- b == 0: LO = all ones, HI = a, `div0` = 1. DIV of most-negative by −1: LO = most-negative, HI = 0.
- Undefined `func`: `result` = 0, `illegal` = 1, HI/LO untouched.
- FSM: IDLE → MUL on accepted MULT/MULTU; IDLE → DIV on accepted DIV/DIVU; MUL/DIV run WIDTH iterations (shift-add / restoring, on magnitudes), then FIX (sign correction, HI/LO write, `out_valid`) → IDLE. All other codes complete in IDLE.

## Timing

- Accept = `in_valid` & `in_ready` at a rising edge.
- Single-cycle op accepted at edge n: `out_valid`, `result`, flags at edge n+1; next op may be accepted at edge n+1.
- MUL/DIV accepted at edge n: `in_ready` low from n+1; iterations on edges n+1…n+WIDTH; FIX at edge n+WIDTH+1 asserts `out_valid` and writes HI/LO; `in_ready` high after that edge. Latency WIDTH+1.
- `in_valid` while `in_ready` low: ignored, no side effect.
- No output back-pressure; `out_valid` is a single-cycle pulse, `result`/flags hold until next completion.
- MFHI/MFLO immediately after MUL/DIV completion return the new values.
- Reset (asserted anytime, including mid-iteration): state IDLE, HI = LO = 0, `result` = 0, `zero` = 1, `out_valid` = `div0` = `illegal` = 0; in-flight operation discarded, no `out_valid`.

## Structure

- Package `alu_pkg`: `func_e` enum (all codes above), `mdu_state_e` (IDLE, MUL, DIV, FIX).
- Sub-module `mdu_iter`: iterative multiply/divide datapath (operand magnitudes, counter, partial product/remainder, sign fix); `alu_mdu` holds FSM, single-cycle ALU, HI/LO, output registers.

## Test plan

- WIDTH=32: SUB a=5, b=7 → next cycle `result`=0xFFFFFFFE, `zero`=0, `out_valid` one cycle.
- SRA b=0x80000000, shamt=4 → 0xF8000000; SRLV a=36, b=0xF0 → 0x0F (uses a[4:0]=4).
- MULT a=−3, b=7 → `out_valid` exactly 33 cycles after accept, HI=0xFFFFFFFF, LO=0xFFFFFFEB; MFHI/MFLO read them back; `in_valid` held high during busy is not accepted.
- DIV a=−7, b=2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF; DIVU a=9, b=0 → LO=0xFFFFFFFF, HI=9, `div0`=1; DIV 0x80000000/−1 → LO=0x80000000, HI=0.
- BGEZ a=0 → `result`=1, `zero`=0; BLEZ a=1 → `result`=0, `zero`=1; `func`=111111 → `illegal`=1, `result`=0.
- `rst_n` low at iteration 10 of a DIVU → no `out_valid`, HI=LO=0, `in_ready` high after release; WIDTH=16 MULTU 0xFFFF·0xFFFF → HI=0xFFFE, LO=0x0001 at 17 cycles.
